signed13_to_bcd: RTL and testbench



---
 rtl/signed13_to_bcd_pkg.sv | 18 +
 rtl/signed13_to_bcd_if.sv | 28 ++
 rtl/signed13_to_bcd_dabble_digit.sv | 9 +
 rtl/signed13_to_bcd.sv | 128 ++++++++++++
 tb/tb_signed13_to_bcd.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/signed13_to_bcd_pkg.sv
// Shared types and constants for the signed 13-bit to sign + BCD converter.
package signed13_to_bcd_pkg;

    localparam int unsigned DEF_WIDTH  = 13;
    localparam int unsigned DEF_DIGITS = 4;
    localparam int unsigned DEF_CNT_W  = 4;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/signed13_to_bcd_if.sv
// Start/busy/done handshake and result bus between a requester and the converter.
interface signed13_to_bcd_if
    import signed13_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
);

    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  ovf_in;
    logic                  busy;
    logic                  done;
    logic                  neg;
    logic                  err;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start, value, ovf_in,
        input  busy, done, neg, err, bcd
    );

    modport slave (
        input  start, value, ovf_in,
        output busy, done, neg, err, bcd
    );

endinterface

// File: rtl/signed13_to_bcd_dabble_digit.sv
// One BCD digit correction step of double dabble: add 3 when the digit is 5 or more.
module signed13_to_bcd_dabble_digit (
    input  logic [3:0] d,
    output logic [3:0] y_c
);

    assign y_c = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/signed13_to_bcd.sv
// Sequential two's-complement to sign + BCD converter (double dabble, one bit per clock).
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits above the ones digit with a blank code.
module signed13_to_bcd
    import signed13_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    signed13_to_bcd_if.slave bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;

    state_t             state;
    logic [WIDTH-1:0]   value_q;
    logic               ovf_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mag;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   sr;
    logic [BCD_W-1:0]   adj_c;
    logic [BCD_W-1:0]   sr_next_c;
    logic [BCD_W-1:0]   result_c;

    logic               busy;
    logic               done;
    logic               neg;
    logic               err;
    logic [BCD_W-1:0]   bcd;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dig
        signed13_to_bcd_dabble_digit u_dig (
            .d   (sr[4*g +: 4]),
            .y_c (adj_c[4*g +: 4])
        );
    end

    // Adjusted digits shifted left, pulling in the next magnitude bit.
    assign sr_next_c = BCD_W'({adj_c, mag[WIDTH-1]});

    // Final display code, computed from the value the last shift produces.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        result_c = sr_next_c;
        if (ovf_q) begin
            result_c = {DIGITS{BCD_ERR}};
        end
`ifdef LEADING_ZERO_BLANK_EN
        else begin
            for (int i = int'(DIGITS) - 1; i > 0; i--) begin
                if (lead && result_c[4*i +: 4] == 4'h0) begin
                    result_c[4*i +: 4] = BCD_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            value_q <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            mag     <= '0;
            cnt     <= '0;
            sr      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            err     <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        value_q <= bus.value;
                        ovf_q   <= bus.ovf_in;
                        busy    <= 1'b1;
                        state   <= ABS;
                    end
                end
                ABS: begin
                    neg_q <= value_q[WIDTH-1];
                    mag   <= value_q[WIDTH-1] ? (~value_q + WIDTH'(1)) : value_q;
                    sr    <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr  <= sr_next_c;
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= result_c;
                        neg   <= neg_q & ~ovf_q;
                        err   <= ovf_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.neg  = neg;
    assign bus.err  = err;
    assign bus.bcd  = bcd;

endmodule

// File: tb/tb_signed13_to_bcd.sv
// Self-checking bench for signed13_to_bcd: vector table, handshake corner cases, random vs. arithmetic model.
module tb_signed13_to_bcd;

    localparam int unsigned WIDTH  = 13;
    localparam int unsigned DIGITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    signed13_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    signed13_to_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [12:0] value;
        logic        ovf;
        logic [15:0] bcd_plain;
        logic [15:0] bcd_blank;
        logic        neg;
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: {err, neg, bcd} from plain integer arithmetic.
    function automatic logic [17:0] ref_model(input logic [12:0] v, input logic ovf);
        int s;
        int m;
        logic [15:0] b;
        bit lead;
        if (ovf) return {1'b1, 1'b0, 16'hEEEE};
        s = (v >= 13'h1000) ? int'(v) - 8192 : int'(v);
        m = (s < 0) ? -s : s;
        for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((m / (10 ** i)) % 10);
        lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 3; i > 0; i--) begin
            if (lead && b[4*i +: 4] == 4'h0) b[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return {1'b0, (s < 0), b};
    endfunction

    // One full conversion: latency, busy window, results, hold after done.
    task automatic run_conv(input string tag, input logic [12:0] v, input logic ovf,
                            input logic [17:0] exp);
        int lat;
        int busy_cnt;
        logic [15:0] b;
        lat = -1;
        busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        bus.ovf_in = ovf;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.value = 13'($urandom);
        bus.ovf_in = 1'($urandom);
        if (bus.busy) busy_cnt++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        check({tag, " latency"}, 32'(lat), 32'd14);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd14);
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, " bcd"}, 32'(bus.bcd), 32'(exp[15:0]));
        check({tag, " neg"}, 32'(bus.neg), 32'(exp[16]));
        check({tag, " err"}, 32'(bus.err), 32'(exp[17]));
        b = bus.bcd;
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, " bcd_hold"}, 32'(bus.bcd), 32'(b));
    endtask

    vec_t vecs[9];
    logic [17:0] exp_v;
    int first, second, n_done;
    logic [15:0] b1, b2;
    logic n2;

    initial begin
        vecs[0] = '{13'd1234, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[1] = '{13'h1000, 1'b0, 16'h4096, 16'h4096, 1'b1, 1'b0};
        vecs[2] = '{13'h1FFF, 1'b0, 16'h0001, 16'hFFF1, 1'b1, 1'b0};
        vecs[3] = '{13'd4095, 1'b0, 16'h4095, 16'h4095, 1'b0, 1'b0};
        vecs[4] = '{13'd5,    1'b1, 16'hEEEE, 16'hEEEE, 1'b0, 1'b1};
        vecs[5] = '{13'd0,    1'b0, 16'h0000, 16'hFFF0, 1'b0, 1'b0};
        vecs[6] = '{13'd7,    1'b0, 16'h0007, 16'hFFF7, 1'b0, 1'b0};
        vecs[7] = '{13'd1000, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{13'h1C19, 1'b0, 16'h0999, 16'hF999, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.value = '0;
        bus.ovf_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset neg", 32'(bus.neg), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset bcd", 32'(bus.bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
`ifdef LEADING_ZERO_BLANK_EN
            exp_v = {vecs[i].err, vecs[i].neg, vecs[i].bcd_blank};
`else
            exp_v = {vecs[i].err, vecs[i].neg, vecs[i].bcd_plain};
`endif
            run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].ovf, exp_v);
        end

        // start held high: restarts every 16 cycles, mid-conversion value change ignored
        first = -1;
        second = -1;
        b1 = '0;
        b2 = '0;
        n2 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 13'd321;
        bus.ovf_in = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
            if (c == 3) bus.value = 13'h1F9C;
            if (bus.done) begin
                if (first < 0) begin
                    first = c;
                    b1 = bus.bcd;
                end else if (second < 0) begin
                    second = c;
                    b2 = bus.bcd;
                    n2 = bus.neg;
                end
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        exp_v = ref_model(13'd321, 1'b0);
        check("held first_latency", 32'(first), 32'd14);
        check("held interval", 32'(second - first), 32'd16);
        check("held first_bcd", 32'(b1), 32'(exp_v[15:0]));
        exp_v = ref_model(13'h1F9C, 1'b0);
        check("held second_bcd", 32'(b2), 32'(exp_v[15:0]));
        check("held second_neg", 32'(n2), 32'(exp_v[16]));
        repeat (3) @(posedge clk);

        // reset while SHIFT has cnt==6 aborts with no done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 13'd2500;
        bus.ovf_in = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort bcd", 32'(bus.bcd), 32'd0);
        check("abort neg", 32'(bus.neg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("abort no_done", 32'(n_done), 32'd0);

        // random operands against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            logic [12:0] rv;
            logic ro;
            rv = 13'($urandom);
            ro = ($urandom_range(0, 7) == 0);
            run_conv($sformatf("rand%0d", i), rv, ro, ref_model(rv, ro));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
